// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: baud-timing derivation, 8N1 frame constants and RX state encodings.
package uart_receiver_pkg;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_sync.sv
// Multi-stage flop synchronizer for bringing an asynchronous level into the clk domain.
module uart_receiver_sync #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) stage_reg[gi] <= RESET_VALUE;
          else       stage_reg[gi] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) stage_reg[gi] <= RESET_VALUE;
          else       stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready output buffer.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME    = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME         = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_LAST = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_LAST = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
  localparam logic [2:0]                     LAST_BIT    = 3'(DATA_BITS - 1);

  logic                           rx_s;
  rx_state_t                      state_reg;
  logic [CLOCK_COUNTER_WIDTH-1:0] counter_reg;
  logic [2:0]                     bit_idx_reg;
  logic [DATA_BITS-1:0]           shift_reg;
  logic                           commit_reg;

  uart_receiver_sync #(
    .WIDTH      (1),
    .STAGES     (2),
    .RESET_VALUE(IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (serial_in),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RX_IDLE;
      counter_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      commit_reg     <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      commit_reg    <= 1'b0;

      case (state_reg)
        RX_IDLE: begin
          counter_reg <= '0;
          if (rx_s != IDLE_LEVEL) state_reg <= RX_START;
        end
        RX_START: begin
          if (counter_reg == SAMPLE_LAST) begin
            counter_reg <= '0;
            bit_idx_reg <= '0;
            // A start bit that has gone high again by mid-symbol was a glitch.
            state_reg   <= (rx_s == IDLE_LEVEL) ? RX_IDLE : RX_DATA;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (counter_reg == SYMBOL_LAST) begin
            counter_reg            <= '0;
            shift_reg[bit_idx_reg] <= rx_s;
            if (bit_idx_reg == LAST_BIT) state_reg <= RX_STOP;
            else                         bit_idx_reg <= bit_idx_reg + 1'b1;
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (counter_reg == SYMBOL_LAST) begin
            counter_reg <= '0;
            if (rx_s == IDLE_LEVEL) begin
              commit_reg <= 1'b1;
              state_reg  <= RX_IDLE;
            end else begin
              framing_error <= 1'b1;
              state_reg     <= RX_BREAK;
            end
          end else begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        RX_BREAK: begin
          // Held-low line must return idle before another frame is accepted.
          counter_reg <= '0;
          if (rx_s == IDLE_LEVEL) state_reg <= RX_IDLE;
        end
        default: begin
          counter_reg <= '0;
          state_reg   <= RX_IDLE;
        end
      endcase

      if (commit_reg) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shift_reg;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver using a short bit period and a received-byte scoreboard.
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 2_100_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b1;
  logic       framing_error;
  logic       overrun;

  uart_receiver #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic       exp_rx;
    logic       exp_fe;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         valid_cyc = 0;
  int         fe_count = 0;
  int         fe_wide = 0;
  logic       fe_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted byte goes to got_q; framing_error pulses are counted.
  always @(negedge clk) begin
    if (data_out_valid && data_out_ready) begin
      got_q.push_back(data_out);
      valid_cyc = cyc;
    end
    if (framing_error) begin
      fe_count = fe_count + 1;
      if (fe_prev) fe_wide = fe_wide + 1;
    end
    fe_prev = framing_error;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    serial_in = 1'b0;
    t_start   = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (BIT) @(negedge clk);
    end
    serial_in = stop;
    repeat (BIT) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got_q.size() < n && t < 4 * BIT) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_scoreboard(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  vec_t vecs[7];
  int   fe_base;
  int   exp_fe_total;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 0,       1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 0,       1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b1, 0,       1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 2 * BIT, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 2 * BIT, 1'b0, 1'b1};
    vecs[5] = '{8'h3C, 1'b1, BIT,     1'b1, 1'b0};
    vecs[6] = '{8'hC3, 1'b1, BIT,     1'b1, 1'b0};

    repeat (4) @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", data_out_valid, 1'b0);
    check("reset_fe", framing_error, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Single frame with latency window check.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_got(1);
    check("a5_latency_ok", ((valid_cyc - t_start) >= (BIT * 19) / 2) &&
                           ((valid_cyc - t_start) <= (BIT * 19) / 2 + 6), 1'b1);
    compare_scoreboard("a5");
    check("a5_fe", fe_count, 0);

    // Table: back-to-back frames, a bad stop bit and recovery.
    fe_base      = fe_count;
    exp_fe_total = 0;
    foreach (vecs[i]) begin
      if (vecs[i].exp_rx) exp_q.push_back(vecs[i].data);
      if (vecs[i].exp_fe) exp_fe_total++;
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (vecs[i].gap) @(negedge clk);
    end
    wait_got(6);
    compare_scoreboard("table");
    check("table_fe_pulses", fe_count - fe_base, exp_fe_total);
    check("fe_single_cycle", fe_wide, 0);
    check("table_overrun", overrun, 1'b0);

    // Short low glitch must be ignored, then a real frame still decodes.
    fe_base = fe_count;
    serial_in = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    serial_in = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_no_rx", got_q.size(), 0);
    check("glitch_no_fe", fe_count - fe_base, 0);
    exp_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1);
    wait_got(1);
    compare_scoreboard("post_glitch");

    // Overrun: buffer full, second byte dropped.
    data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (8) @(negedge clk);
    check("ovr_data_held", data_out, 8'h11);
    check("ovr_valid_held", data_out_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    exp_q.push_back(8'h11);
    data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_popped_valid", data_out_valid, 1'b0);
    check("ovr_data_kept", data_out, 8'h11);
    check("ovr_sticky", overrun, 1'b1);
    compare_scoreboard("ovr");

    // Reset mid-frame: partial 0x77 never delivered.
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (BIT * 5 + BIT / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_valid", data_out_valid, 1'b0);
        check("rst_mid_data", data_out, 8'h00);
        check("rst_mid_overrun", overrun, 1'b0);
        check("rst_mid_fe", framing_error, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    wait_got(1);
    compare_scoreboard("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
